// File: rtl/pipeline_ctrl_sequencer.sv
// Pipeline control sequencer: arbitrates memory freeze, branch flush and load-use stall for the 5-stage core.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 LoadUseHazard,
   input  logic                 BranchTaken,
   input  logic                 MemBusy,
   output logic                 PCWrite,
   output logic                 IF_ID_Write,
   output logic                 IF_ID_Flush,
   output logic                 ID_EX_Flush,
   output logic                 PipeHold,
   output logic                 MEM_WB_Bubble,
   output logic                 MemTimeout,
   output logic [1:0]           CtrlState,
   output logic [CNT_WIDTH-1:0] StallCycles,
   output logic [CNT_WIDTH-1:0] FlushCount
);

   localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);
   localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);

   localparam logic [1:0] S_RUN      = 2'b00;
   localparam logic [1:0] S_MEM_WAIT = 2'b01;
   localparam logic [1:0] S_HALT     = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              pend_flush_q, pend_flush_d;
   logic              timeout_q, timeout_d;
   logic              flush_eff_c;

   // Control state; reset is asynchronous so a hung core can always be recovered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_RUN;
         wait_cnt_q   <= '0;
         pend_flush_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         pend_flush_q <= pend_flush_d;
         timeout_q    <= timeout_d;
      end
   end

   assign flush_eff_c = BranchTaken | pend_flush_q;

   // Next state and Mealy controls: HALT > freeze > flush > load-use stall > normal.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      pend_flush_d  = pend_flush_q;
      timeout_d     = timeout_q;
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      PipeHold      = 1'b0;
      MEM_WB_Bubble = 1'b0;

      if (state_q == S_HALT) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         PipeHold      = 1'b1;
         MEM_WB_Bubble = 1'b1;
      end else if (MemBusy) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         PipeHold      = 1'b1;
         MEM_WB_Bubble = 1'b1;
         pend_flush_d  = pend_flush_q | BranchTaken;
         if (state_q == S_MEM_WAIT) begin
            // wait_cnt counts busy cycles spent in MEM_WAIT, so a run of MEM_WAIT_MAX+1 still recovers
            if (TIMEOUT_EN && (wait_cnt_q == WAIT_LIMIT)) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end else if (TIMEOUT_EN) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end else begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = '0;
         end
      end else begin
         state_d    = S_RUN;
         wait_cnt_d = '0;
         if (flush_eff_c) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            pend_flush_d = 1'b0;
         end else if (LoadUseHazard) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end
      end
   end

   assign CtrlState  = state_q;
   assign MemTimeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] flush_cnt_q;

   // PC is held exactly on stall, freeze and HALT cycles; IF/ID flush marks an applied flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!PCWrite && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         end
         if (IF_ID_Flush && !(&flush_cnt_q)) begin
            flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign StallCycles = stall_cnt_q;
   assign FlushCount  = flush_cnt_q;
`else
   assign StallCycles = '0;
   assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Bench for pipeline_ctrl_sequencer: three instances (timeout 15, 3, disabled) against a cycle-level behavioural model.
module tb_pipeline_ctrl_sequencer;

   localparam int NI = 3;
   localparam int CW = 16;
   localparam int MAXV [NI] = '{15, 3, 0};

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic luh = 1'b0, bt = 1'b0, mb = 1'b0;

   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeHold, MEM_WB_Bubble, MemTimeout}
   wire [6:0]    ctl [NI];
   wire [1:0]    st  [NI];
   wire [CW-1:0] sc  [NI];
   wire [CW-1:0] fc  [NI];

   int n_cmp = 0;
   int n_bad = 0;

   // model state per instance
   bit halted [NI];
   bit pend   [NI];
   bit tout   [NI];
   int run    [NI];
   int msc    [NI];
   int mfc    [NI];

   always #5 clk = ~clk;

   pipeline_ctrl_sequencer #(.MEM_WAIT_MAX(15), .CNT_WIDTH(CW)) u_dut0 (
      .clk(clk), .reset(reset), .LoadUseHazard(luh), .BranchTaken(bt), .MemBusy(mb),
      .PCWrite(ctl[0][6]), .IF_ID_Write(ctl[0][5]), .IF_ID_Flush(ctl[0][4]), .ID_EX_Flush(ctl[0][3]),
      .PipeHold(ctl[0][2]), .MEM_WB_Bubble(ctl[0][1]), .MemTimeout(ctl[0][0]),
      .CtrlState(st[0]), .StallCycles(sc[0]), .FlushCount(fc[0]));

   pipeline_ctrl_sequencer #(.MEM_WAIT_MAX(3), .CNT_WIDTH(CW)) u_dut1 (
      .clk(clk), .reset(reset), .LoadUseHazard(luh), .BranchTaken(bt), .MemBusy(mb),
      .PCWrite(ctl[1][6]), .IF_ID_Write(ctl[1][5]), .IF_ID_Flush(ctl[1][4]), .ID_EX_Flush(ctl[1][3]),
      .PipeHold(ctl[1][2]), .MEM_WB_Bubble(ctl[1][1]), .MemTimeout(ctl[1][0]),
      .CtrlState(st[1]), .StallCycles(sc[1]), .FlushCount(fc[1]));

   pipeline_ctrl_sequencer #(.MEM_WAIT_MAX(0), .CNT_WIDTH(CW)) u_dut2 (
      .clk(clk), .reset(reset), .LoadUseHazard(luh), .BranchTaken(bt), .MemBusy(mb),
      .PCWrite(ctl[2][6]), .IF_ID_Write(ctl[2][5]), .IF_ID_Flush(ctl[2][4]), .ID_EX_Flush(ctl[2][3]),
      .PipeHold(ctl[2][2]), .MEM_WB_Bubble(ctl[2][1]), .MemTimeout(ctl[2][0]),
      .CtrlState(st[2]), .StallCycles(sc[2]), .FlushCount(fc[2]));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_ctl(input int i);
      logic [5:0] a;
      if (halted[i] || mb)  a = 6'b000011;
      else if (bt || pend[i]) a = 6'b111100;
      else if (luh)         a = 6'b000100;
      else                  a = 6'b110000;
      return {a, tout[i]};
   endfunction

   function automatic logic [1:0] exp_st(input int i);
      if (halted[i]) return 2'b10;
      return (run[i] > 0) ? 2'b01 : 2'b00;
   endfunction

   function automatic int exp_cnt(input int v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return (v < 0) ? v : 0;
`endif
   endfunction

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("ctl[%0d]", i), 32'(ctl[i]), 32'(exp_ctl(i)));
         check($sformatf("state[%0d]", i), 32'(st[i]), 32'(exp_st(i)));
         check($sformatf("stall_cnt[%0d]", i), 32'(sc[i]), 32'(exp_cnt(msc[i])));
         check($sformatf("flush_cnt[%0d]", i), 32'(fc[i]), 32'(exp_cnt(mfc[i])));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         halted[i] = 1'b0; pend[i] = 1'b0; tout[i] = 1'b0;
         run[i] = 0; msc[i] = 0; mfc[i] = 0;
      end
   endtask

   // One clock edge of the behavioural rules, using the inputs held through the cycle.
   task automatic model_update();
      for (int i = 0; i < NI; i++) begin
         if (halted[i]) begin
            if (msc[i] < 65535) msc[i]++;
         end else if (mb) begin
            run[i]++;
            pend[i] = pend[i] | bt;
            if (msc[i] < 65535) msc[i]++;
            if (MAXV[i] != 0 && run[i] == MAXV[i] + 2) begin
               halted[i] = 1'b1;
               tout[i]   = 1'b1;
            end
         end else begin
            run[i] = 0;
            if (bt || pend[i]) begin
               pend[i] = 1'b0;
               if (mfc[i] < 65535) mfc[i]++;
            end else if (luh) begin
               if (msc[i] < 65535) msc[i]++;
            end
         end
      end
   endtask

   task automatic drive(input logic l, input logic b, input logic m);
      luh = l; bt = b; mb = m;
      @(negedge clk);
      compare_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step(input logic l, input logic b, input logic m);
      drive(l, b, m);
      tick();
   endtask

   // Reset is asserted between edges and checked before any clock edge arrives.
   task automatic do_reset();
      luh = 1'b0; bt = 1'b0; mb = 1'b0;
      reset = 1'b0;
      model_reset();
      #2;
      compare_all();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit mbv;
      model_reset();
      #3;
      do_reset();

      // idle after reset
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0);
         check("idle_ctl", 32'(ctl[0]), 32'(7'b1100000));
         check("idle_state", 32'(st[0]), 32'(2'b00));
         tick();
      end

      // load-use stall
      drive(1, 0, 0);
      check("luh_ctl", 32'(ctl[0]), 32'(7'b0001000));
      tick();
      drive(0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
      check("luh_stallcnt", 32'(sc[0]), 32'd1);
`else
      check("luh_stallcnt", 32'(sc[0]), 32'd0);
`endif
      tick();

      // flush overrides simultaneous load-use
      drive(1, 1, 0);
      check("flush_over_luh", 32'(ctl[0]), 32'(7'b1111000));
      tick();

      // branch during freeze is deferred to first non-busy cycle
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         drive(0, k == 2, 1);
         check("freeze_ctl", 32'(ctl[1]), 32'(7'b0000110));
         tick();
      end
      drive(0, 0, 0);
      check("pending_flush", 32'(ctl[0]), 32'(7'b1111000));
      tick();
      drive(0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
      check("flushcnt_one", 32'(fc[0]), 32'd1);
`else
      check("flushcnt_one", 32'(fc[0]), 32'd0);
`endif
      tick();

      // timeout with MEM_WAIT_MAX=3
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         drive(0, 0, 1);
         check("to3_state", 32'(st[1]), (k == 1) ? 32'd0 : (k <= 5) ? 32'd1 : 32'd2);
         tick();
      end
      drive(0, 0, 0);
      check("halt_sticky_state", 32'(st[1]), 32'd2);
      check("halt_sticky_ctl", 32'(ctl[1]), 32'(7'b0000111));
      tick();
      do_reset();
      check("halt_reset_state", 32'(st[1]), 32'd0);
      check("halt_reset_tout", 32'(ctl[1][0]), 32'd0);

      // MEM_WAIT_MAX=15: run of 16 recovers, run of 17 halts
      for (int k = 0; k < 16; k++) step(0, 0, 1);
      drive(0, 0, 0);
      check("run16_recover", 32'(ctl[0]), 32'(7'b1100000));
      tick();
      drive(0, 0, 0);
      check("run16_state", 32'(st[0]), 32'd0);
      tick();
      do_reset();
      for (int k = 0; k < 17; k++) step(0, 0, 1);
      drive(0, 0, 1);
      check("run17_halt", 32'(st[0]), 32'd2);
      tick();

      // timeout disabled
      do_reset();
      for (int k = 0; k < 100; k++) step(0, 0, 1);
      drive(0, 0, 0);
      check("nolimit_state", 32'(st[2]), 32'd1);
      check("nolimit_ctl", 32'(ctl[2]), 32'(7'b1100000));
      tick();
      drive(0, 0, 0);
      check("nolimit_run", 32'(st[2]), 32'd0);
      tick();

      // randomized traffic with occasional mid-operation resets
      do_reset();
      mbv = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end
         if ($urandom_range(0, 99) < 20) mbv = ~mbv;
         step(logic'($urandom_range(0, 99) < 30), logic'($urandom_range(0, 99) < 15), mbv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
